// File: rtl/regfile_port_master_if.sv
// Command, load, dump and register-file port bundle for regfile_port_master.
// The master modport is the controller side; slave is the environment side.
interface regfile_port_master_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_OP;
    logic [AW-1:0] CMD_BASE;
    logic [3:0]    CMD_COUNT;

    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA;

    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;

    logic [AW-1:0] A3;
    logic          WE3;
    logic [DW-1:0] WD3;
    logic [AW-1:0] A1;
    logic [DW-1:0] RD1;

    logic          BUSY;
    logic          DONE;

    modport master (
        input  CMD_VALID, CMD_OP, CMD_BASE, CMD_COUNT,
        input  IN_VALID, IN_DATA, OUT_READY, RD1,
        output CMD_READY, IN_READY, OUT_VALID, OUT_DATA,
        output A3, WE3, WD3, A1, BUSY, DONE
    );

    modport slave (
        output CMD_VALID, CMD_OP, CMD_BASE, CMD_COUNT,
        output IN_VALID, IN_DATA, OUT_READY, RD1,
        input  CMD_READY, IN_READY, OUT_VALID, OUT_DATA,
        input  A3, WE3, WD3, A1, BUSY, DONE
    );
endinterface

// File: rtl/regfile_port_master.sv
// Burst load/dump controller driving the register file write port and read port 1.
// Loads stream one word per cycle; dumps fetch then present one registered word.
module regfile_port_master #(
    parameter int NREGS = 8,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic                   CLK,
    input logic                   RESET,
    regfile_port_master_if.master bus
);
    localparam int LW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] addr_q, addr_d;
    logic [3:0]    rem_q, rem_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic [LW-1:0] addr_inc;
    logic [AW-1:0] addr_ext;
    logic          last;
    logic          in_ready;
    logic          unused_base;

    // Power-of-two register count: natural overflow gives the wrap.
    assign addr_inc    = addr_q + LW'(1);
    assign addr_ext    = AW'(addr_q);
    assign last        = (rem_q == 4'd1);
    assign in_ready    = (state_q == S_LOAD);
    assign unused_base = ^bus.CMD_BASE[AW-1:LW];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.CMD_VALID) begin
                    addr_d = bus.CMD_BASE[LW-1:0];
                    rem_d  = bus.CMD_COUNT;
                    if (bus.CMD_COUNT == 4'd0) begin
                        state_d = S_FINISH;
                    end else if (bus.CMD_OP) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.IN_VALID) begin
                    addr_d = addr_inc;
                    rem_d  = rem_q - 4'd1;
                    if (last) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FETCH: begin
                out_data_d  = bus.RD1;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (bus.OUT_READY) begin
                    addr_d      = addr_inc;
                    rem_d       = rem_q - 4'd1;
                    out_valid_d = 1'b0;
                    state_d     = last ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.CMD_READY = (state_q == S_IDLE);
    assign bus.IN_READY  = in_ready;
    assign bus.WE3       = in_ready & bus.IN_VALID;
    assign bus.A3        = addr_ext;
    assign bus.WD3       = bus.IN_DATA;
    assign bus.A1        = addr_ext;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.BUSY      = (state_q != S_IDLE);
    assign bus.DONE      = (state_q == S_FINISH);
endmodule

// File: tb/tb_regfile_port_master.sv
// Scoreboard bench for regfile_port_master with an 8x32 register file model.
// Stimulus pushes expected writes/dump words; a negedge monitor pops and compares.
module tb_regfile_port_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    regfile_port_master_if #(.AW(5), .DW(32)) bus ();

    regfile_port_master #(.NREGS(8), .AW(5), .DW(32)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wexp_t;

    wexp_t       wq[$];
    logic [31:0] dq[$];
    logic [31:0] rf [8];
    logic [31:0] ld [8];
    logic [31:0] held_data;
    logic        held = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          nwr = 0;
    int          ndone = 0;

    // Register file model: preload known contents, then combinational read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) rf[i] <= 32'hDEAD_0000 + 32'(i);
        end else if (bus.WE3) begin
            rf[bus.A3[2:0]] <= bus.WD3;
        end
    end
    assign bus.RD1 = rf[bus.A1[2:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.WE3) begin
                nwr++;
                if (wq.size() == 0) begin
                    chk("wr_unexpected", {27'd0, bus.A3}, 32'hFFFF_FFFF);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wr_addr", {27'd0, bus.A3}, {27'd0, e.a});
                    chk("wr_data", bus.WD3, e.d);
                end
            end
            if (bus.BUSY) begin
                chk("a1_hi", {30'd0, bus.A1[4:3]}, 32'd0);
                chk("a3_hi", {30'd0, bus.A3[4:3]}, 32'd0);
            end
            if (bus.OUT_VALID) begin
                if (held) chk("out_stable", bus.OUT_DATA, held_data);
                if (bus.OUT_READY) begin
                    held = 1'b0;
                    if (dq.size() == 0) begin
                        chk("out_unexpected", bus.OUT_DATA, 32'hFFFF_FFFF);
                    end else begin
                        chk("out_data", bus.OUT_DATA, dq.pop_front());
                    end
                end else begin
                    held = 1'b1;
                    held_data = bus.OUT_DATA;
                end
            end else begin
                held = 1'b0;
            end
            if (bus.DONE) ndone++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input int base, input int cnt);
        chk("cmd_ready_idle", 32'(bus.CMD_READY), 32'd1);
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        bus.CMD_BASE  = 5'(base);
        bus.CMD_COUNT = 4'(cnt);
        tick();
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic do_load(input int base, input int cnt, input int gap);
        int n0;
        int d0;
        n0 = nwr;
        d0 = ndone;
        for (int i = 0; i < cnt; i++)
            wq.push_back(wexp_t'{a: 5'((base + i) % 8), d: ld[i]});
        issue(1'b0, base, cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = ld[i];
            tick();
            bus.IN_VALID = 1'b0;
            if (i < cnt - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk("busy_gap", 32'(bus.BUSY), 32'd1);
                    tick();
                end
            end
        end
        chk("load_done_next", 32'(bus.DONE), 32'd1);
        tick();
        chk("load_writes", nwr - n0, cnt);
        chk("load_done_cnt", ndone - d0, 1);
    endtask

    // mode 1 cycles OUT_READY through 1,0,0,1; noise offers a rival command.
    task automatic do_dump(input int base, input int cnt, input int mode,
                           input bit lat, input bit noise);
        int   n0;
        int   d0;
        int   p;
        bit   got;
        logic [3:0] pat;
        n0  = nwr;
        d0  = ndone;
        p   = 0;
        got = 1'b0;
        pat = 4'b1001;
        issue(1'b1, base, cnt);
        if (noise) begin
            bus.CMD_VALID = 1'b1;
            bus.CMD_OP    = 1'b0;
            bus.CMD_BASE  = 5'd5;
            bus.CMD_COUNT = 4'd1;
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = 32'h0BAD_0BAD;
        end
        if (lat) begin
            chk("dump_lat_fetch", 32'(bus.OUT_VALID), 32'd0);
            bus.OUT_READY = 1'b0;
            tick();
            chk("dump_lat_send", 32'(bus.OUT_VALID), 32'd1);
        end
        for (int c = 0; c < 100 && !got; c++) begin
            if (bus.DONE) begin
                got = 1'b1;
            end else begin
                if (noise) chk("cmd_ready_busy", 32'(bus.CMD_READY), 32'd0);
                bus.OUT_READY = (mode == 1) ? pat[p % 4] : 1'b1;
                p++;
                tick();
            end
        end
        bus.CMD_VALID = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        chk("dump_finished", 32'(got), 32'd1);
        tick();
        chk("dump_done_cnt", ndone - d0, 1);
        chk("dump_no_write", nwr - n0, 0);
    endtask

    task automatic do_zero(input logic op);
        int n0;
        int d0;
        n0 = nwr;
        d0 = ndone;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 32'h5A5A_5A5A;
        issue(op, 3, 0);
        chk("zero_done", 32'(bus.DONE), 32'd1);
        chk("zero_we3", 32'(bus.WE3), 32'd0);
        chk("zero_outv", 32'(bus.OUT_VALID), 32'd0);
        tick();
        bus.IN_VALID = 1'b0;
        chk("zero_cmd_ready", 32'(bus.CMD_READY), 32'd1);
        chk("zero_done_cnt", ndone - d0, 1);
        chk("zero_writes", nwr - n0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int d0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = 1'b0;
        bus.CMD_BASE  = '0;
        bus.CMD_COUNT = '0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.OUT_READY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        preload = 1'b0;

        chk("rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_we3", 32'(bus.WE3), 32'd0);
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_out_data", bus.OUT_DATA, 32'd0);
        chk("rst_a1", {27'd0, bus.A1}, 32'd0);
        tick();

        // Wrapping load 6,7,0 then wrapping dump 6,7,0,1.
        ld[0] = 32'hA; ld[1] = 32'hB; ld[2] = 32'hC;
        do_load(6, 3, 0);
        chk("rf6", rf[6], 32'hA);
        chk("rf7", rf[7], 32'hB);
        chk("rf0", rf[0], 32'hC);
        dq.push_back(32'hA);
        dq.push_back(32'hB);
        dq.push_back(32'hC);
        dq.push_back(32'hDEAD_0001);
        do_dump(6, 4, 0, 1'b1, 1'b0);

        // Full load then immediate stalled dump.
        for (int i = 0; i < 8; i++) ld[i] = 32'h1000 + 32'(i);
        do_load(0, 8, 0);
        for (int i = 0; i < 8; i++) dq.push_back(32'h1000 + 32'(i));
        do_dump(0, 8, 1, 1'b0, 1'b0);

        // Load with gaps between words.
        ld[0] = 32'h33; ld[1] = 32'h44;
        do_load(3, 2, 3);
        chk("rf3_gap", rf[3], 32'h33);
        chk("rf4_gap", rf[4], 32'h44);

        do_zero(1'b0);
        do_zero(1'b1);

        // Asynchronous reset after two of five load words.
        n0 = nwr;
        d0 = ndone;
        wq.push_back(wexp_t'{a: 5'd2, d: 32'h5550});
        wq.push_back(wexp_t'{a: 5'd3, d: 32'h5551});
        issue(1'b0, 2, 5);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 32'h5550;
        tick();
        bus.IN_DATA  = 32'h5551;
        tick();
        bus.IN_DATA  = 32'h5552;
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        chk("mid_rst_we3", 32'(bus.WE3), 32'd0);
        chk("mid_rst_outv", 32'(bus.OUT_VALID), 32'd0);
        chk("mid_rst_done", 32'(bus.DONE), 32'd0);
        bus.IN_VALID = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_writes", nwr - n0, 2);
        chk("mid_rst_no_done", ndone - d0, 0);
        chk("rf2_rst", rf[2], 32'h5550);
        chk("rf3_rst", rf[3], 32'h5551);
        chk("rf4_rst", rf[4], 32'h44);
        chk("rf5_rst", rf[5], 32'h1005);
        chk("rf6_rst", rf[6], 32'h1006);
        dq.push_back(32'h5550);
        dq.push_back(32'h5551);
        dq.push_back(32'h44);
        dq.push_back(32'h1005);
        dq.push_back(32'h1006);
        do_dump(2, 5, 0, 1'b0, 1'b0);

        // Rival command offered throughout a wrapping dump.
        dq.push_back(32'h1007);
        dq.push_back(32'h1000);
        dq.push_back(32'h1001);
        do_dump(7, 3, 1, 1'b0, 1'b1);
        chk("rf5_untouched", rf[5], 32'h1005);

        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
